// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding and defaults for the UART TX arbiter (package uart_arb_pkg).
// Optional packet lock is enabled with macro UART_ARB_PACKET_LOCK_EN.
package uart_arb_pkg;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_LAUNCH_ENC    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_LAUNCH    = ST_LAUNCH_ENC,
        ST_WAIT_DONE = ST_WAIT_DONE_ENC
    } arb_state_t;

    localparam int DEFAULT_LAUNCH_TIMEOUT = 1023;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART TX signal bundle for uart_tx_arbiter.
// IN_REQ_LAST exists only when UART_ARB_PACKET_LOCK_EN is defined.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ                  = 4,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int REQ_ID_W                 = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                          IN_REQ_VALID;
    logic [NUM_REQ*NUM_OF_DATA_BITS_IN_PACK-1:0] IN_REQ_DATA;
    logic [NUM_REQ-1:0]                          OUT_REQ_READY;
`ifdef UART_ARB_PACKET_LOCK_EN
    logic [NUM_REQ-1:0]                          IN_REQ_LAST;
`endif
    logic                                        OUT_UART_TX_LAUNCH;
    logic [NUM_OF_DATA_BITS_IN_PACK-1:0]         OUT_UART_TX_DATA;
    logic                                        IN_UART_TX_ACTIVE;
    logic                                        IN_UART_TX_DONE;
    logic [REQ_ID_W-1:0]                         OUT_GRANT_ID;
    logic                                        OUT_BUSY;
    logic                                        OUT_TIMEOUT_ERROR;
    logic                                        IN_CLEAR_ERROR;

    modport slave (
`ifdef UART_ARB_PACKET_LOCK_EN
        input  IN_REQ_LAST,
`endif
        input  IN_REQ_VALID, IN_REQ_DATA, IN_UART_TX_ACTIVE, IN_UART_TX_DONE, IN_CLEAR_ERROR,
        output OUT_REQ_READY, OUT_UART_TX_LAUNCH, OUT_UART_TX_DATA, OUT_GRANT_ID,
               OUT_BUSY, OUT_TIMEOUT_ERROR
    );

    modport master (
`ifdef UART_ARB_PACKET_LOCK_EN
        output IN_REQ_LAST,
`endif
        output IN_REQ_VALID, IN_REQ_DATA, IN_UART_TX_ACTIVE, IN_UART_TX_DONE, IN_CLEAR_ERROR,
        input  OUT_REQ_READY, OUT_UART_TX_LAUNCH, OUT_UART_TX_DATA, OUT_GRANT_ID,
               OUT_BUSY, OUT_TIMEOUT_ERROR
    );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// Kept free of UART specifics so an RX dispatcher can reuse it.
module uart_rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [REQ_ID_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [REQ_ID_W-1:0] idx_o,
    output logic                any_o
);

    always_comb begin
        int cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!any_o && req_i[cand[REQ_ID_W-1:0]]) begin
                any_o                      = 1'b1;
                idx_o                      = cand[REQ_ID_W-1:0];
                gnt_o[cand[REQ_ID_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_PACKET_LOCK_EN to keep the grant across multi-pack packets (IN_REQ_LAST).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ                  = 4,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int LAUNCH_TIMEOUT           = DEFAULT_LAUNCH_TIMEOUT,
    parameter int REQ_ID_W                 = $clog2(NUM_REQ)
) (
    input  logic             IN_CLOCK,
    input  logic             IN_RESET_N,
    uart_tx_arbiter_if.slave bus
);

    localparam int W     = NUM_OF_DATA_BITS_IN_PACK;
    localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [REQ_ID_W-1:0] ptr_q, ptr_d;
    logic [REQ_ID_W-1:0] grant_q, grant_d;
    logic                launch_q, launch_d;
    logic [W-1:0]        data_q, data_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  arb_req, arb_gnt;
    logic [REQ_ID_W-1:0] arb_ptr, arb_idx;
    logic                arb_any;

    function automatic logic [REQ_ID_W-1:0] ptr_after(input logic [REQ_ID_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + REQ_ID_W'(1);
    endfunction

`ifdef UART_ARB_PACKET_LOCK_EN
    logic lock_q, lock_d;

    // While a packet is open only its owner may be picked again.
    always_comb begin
        arb_req = bus.IN_REQ_VALID;
        arb_ptr = ptr_q;
        if (lock_q) begin
            arb_req = bus.IN_REQ_VALID & (NUM_REQ'(1) << grant_q);
            arb_ptr = grant_q;
        end
    end
`else
    assign arb_req = bus.IN_REQ_VALID;
    assign arb_ptr = ptr_q;
`endif

    uart_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .REQ_ID_W (REQ_ID_W)
    ) u_rr (
        .req_i (arb_req),
        .ptr_i (arb_ptr),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        launch_d = launch_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
`ifdef UART_ARB_PACKET_LOCK_EN
        lock_d   = lock_q;
`endif
        // Clear first so a timeout in the same cycle still sets the flag.
        if (bus.IN_CLEAR_ERROR) err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d  = ST_LAUNCH;
                    launch_d = 1'b1;
                    cnt_d    = '0;
                    grant_d  = arb_idx;
                    data_d   = bus.IN_REQ_DATA[arb_idx*W +: W];
`ifdef UART_ARB_PACKET_LOCK_EN
                    if (bus.IN_REQ_LAST[arb_idx]) begin
                        lock_d = 1'b0;
                        ptr_d  = ptr_after(arb_idx);
                    end else begin
                        lock_d = 1'b1;
                    end
`else
                    ptr_d    = ptr_after(arb_idx);
`endif
                end
            end
            ST_LAUNCH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.IN_UART_TX_ACTIVE) begin
                    launch_d = 1'b0;
                    state_d  = ST_WAIT_DONE;
                end else if (cnt_d == CNT_W'(LAUNCH_TIMEOUT)) begin
                    launch_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
`ifdef UART_ARB_PACKET_LOCK_EN
                    if (lock_q) begin
                        lock_d = 1'b0;
                        ptr_d  = ptr_after(grant_q);
                    end
`endif
                end
            end
            ST_WAIT_DONE: begin
                // Entry implies ACTIVE was high, so ACTIVE low here is its falling edge.
                if (bus.IN_UART_TX_DONE || !bus.IN_UART_TX_ACTIVE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            launch_q <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            launch_q <= launch_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

`ifdef UART_ARB_PACKET_LOCK_EN
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) lock_q <= 1'b0;
        else             lock_q <= lock_d;
    end
`endif

    assign bus.OUT_REQ_READY      = (state_q == ST_IDLE) ? arb_gnt : '0;
    assign bus.OUT_UART_TX_LAUNCH = launch_q;
    assign bus.OUT_UART_TX_DATA   = data_q;
    assign bus.OUT_GRANT_ID       = grant_q;
    assign bus.OUT_BUSY           = (state_q != ST_IDLE);
    assign bus.OUT_TIMEOUT_ERROR  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: random requesters and a behavioural UART against a round-robin model.
// Packet-lock steps are built only with UART_ARB_PACKET_LOCK_EN.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .NUM_OF_DATA_BITS_IN_PACK(W)) bif ();

    uart_tx_arbiter #(
        .NUM_REQ                  (N),
        .NUM_OF_DATA_BITS_IN_PACK (W),
        .LAUNCH_TIMEOUT           (TMO)
    ) dut (
        .IN_CLOCK   (clk),
        .IN_RESET_N (rst_n),
        .bus        (bif)
    );

    int           tests = 0;
    int           fails = 0;
    bit           uart_en = 1'b1;
    logic [N-1:0] vld = '0;
    logic [W-1:0] rdata [N];
    logic [N-1:0] m_last = '1;
    int           m_ptr = 0;
    bit           m_lock = 1'b0;
    int           m_lock_id = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first valid requester scanning from the pointer with wraparound.
    function automatic int model_pick(input logic [N-1:0] v);
        if (m_lock) return v[m_lock_id] ? m_lock_id : -1;
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) bif.IN_REQ_DATA[k*W +: W] = rdata[k];
        bif.IN_REQ_VALID = vld;
`ifdef UART_ARB_PACKET_LOCK_EN
        bif.IN_REQ_LAST = m_last;
`endif
        #1;
    endtask

    // Waits for the accept, checks it against the model, then retires or refreshes the pack.
    task automatic serve(input bit keep, output int lat);
        int w;
        logic [W-1:0] d;
        w   = model_pick(vld);
        lat = 0;
        while (bif.OUT_REQ_READY == '0 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("ready_onehot", 32'(bif.OUT_REQ_READY), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
            d = rdata[w];
            @(negedge clk);
            chk("grant_id", 32'(bif.OUT_GRANT_ID), 32'(w));
            chk("tx_data", 32'(bif.OUT_UART_TX_DATA), 32'(d));
            chk("launch_set", 32'(bif.OUT_UART_TX_LAUNCH), 32'd1);
            chk("busy_after_accept", 32'(bif.OUT_BUSY), 32'd1);
            chk("no_back_to_back", 32'(bif.OUT_REQ_READY), 32'd0);
            if (m_last[w]) begin
                m_ptr  = (w + 1) % N;
                m_lock = 1'b0;
            end else begin
                m_lock    = 1'b1;
                m_lock_id = w;
            end
            if (keep) rdata[w] = W'($urandom);
            else      vld[w] = 1'b0;
            drive();
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bif.OUT_BUSY !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("return_idle", 32'(bif.OUT_BUSY), 32'd0);
    endtask

    // Behavioural UART: answers a launch with ACTIVE after 0..2 cycles, then a DONE pulse.
    initial begin
        bif.IN_UART_TX_ACTIVE = 1'b0;
        bif.IN_UART_TX_DONE   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (uart_en && bif.OUT_UART_TX_LAUNCH === 1'b1) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                bif.IN_UART_TX_ACTIVE = 1'b1;
                repeat ($urandom_range(2, 5)) begin @(posedge clk); #1; end
                bif.IN_UART_TX_ACTIVE = 1'b0;
                bif.IN_UART_TX_DONE   = 1'b1;
                @(posedge clk);
                #1;
                bif.IN_UART_TX_DONE   = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int cnt;
        for (int k = 0; k < N; k++) rdata[k] = '0;
        bif.IN_CLEAR_ERROR = 1'b0;
        drive();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bif.OUT_BUSY), 32'd0);
        chk("rst_ready", 32'(bif.OUT_REQ_READY), 32'd0);
        chk("rst_launch", 32'(bif.OUT_UART_TX_LAUNCH), 32'd0);
        chk("rst_data", 32'(bif.OUT_UART_TX_DATA), 32'd0);
        chk("rst_grant", 32'(bif.OUT_GRANT_ID), 32'd0);
        chk("rst_err", 32'(bif.OUT_TIMEOUT_ERROR), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_busy", 32'(bif.OUT_BUSY), 32'd0);
            chk("idle_ready", 32'(bif.OUT_REQ_READY), 32'd0);
            chk("idle_launch", 32'(bif.OUT_UART_TX_LAUNCH), 32'd0);
        end

        // Single requester 2 with 0xA5
        @(posedge clk);
        #1;
        rdata[2] = 8'hA5;
        vld[2]   = 1'b1;
        drive();
        @(negedge clk);
        serve(1'b0, lat);
        chk("zero_latency", 32'(lat), 32'd0);
        vld[0] = 1'b1;
        drive();
        cnt = 0;
        while (bif.IN_UART_TX_ACTIVE !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("launch_until_active", 32'(bif.OUT_UART_TX_LAUNCH), 32'd1);
        @(negedge clk);
        chk("launch_dropped", 32'(bif.OUT_UART_TX_LAUNCH), 32'd0);
        chk("wait_done_busy", 32'(bif.OUT_BUSY), 32'd1);
        vld[0] = 1'b0;
        drive();
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ghost_valid_ready", 32'(bif.OUT_REQ_READY), 32'd0);
        chk("ghost_valid_grant", 32'(bif.OUT_GRANT_ID), 32'd2);

        // Randomized request mixes
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < N; k++)
                if (!vld[k] && $urandom_range(0, 1) == 1) begin
                    vld[k]   = 1'b1;
                    rdata[k] = W'($urandom);
                end
            if (vld == '0) begin
                vld[f % N]   = 1'b1;
                rdata[f % N] = W'($urandom);
            end
            drive();
            serve(1'b0, lat);
            wait_idle();
        end
        while (vld != '0) begin
            serve(1'b0, lat);
            wait_idle();
        end

        // Launch timeout, sticky error, clear
        uart_en  = 1'b0;
        vld[1]   = 1'b1;
        rdata[1] = W'($urandom);
        drive();
        serve(1'b0, lat);
        cnt = 0;
        while (bif.OUT_UART_TX_LAUNCH === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_launch_cycles", 32'(cnt), 32'(TMO));
        chk("timeout_err_set", 32'(bif.OUT_TIMEOUT_ERROR), 32'd1);
        chk("timeout_idle", 32'(bif.OUT_BUSY), 32'd0);
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(bif.OUT_TIMEOUT_ERROR), 32'd1);
        bif.IN_CLEAR_ERROR = 1'b1;
        @(negedge clk);
        chk("err_cleared", 32'(bif.OUT_TIMEOUT_ERROR), 32'd0);
        vld[2]   = 1'b1;
        rdata[2] = W'($urandom);
        drive();
        serve(1'b0, lat);
        cnt = 0;
        while (bif.OUT_UART_TX_LAUNCH === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("set_wins_over_clear", 32'(bif.OUT_TIMEOUT_ERROR), 32'd1);
        @(negedge clk);
        chk("clear_after_set", 32'(bif.OUT_TIMEOUT_ERROR), 32'd0);
        bif.IN_CLEAR_ERROR = 1'b0;
        uart_en = 1'b1;

        // Asynchronous reset during WAIT_DONE
        vld[1]   = 1'b1;
        rdata[1] = W'($urandom);
        drive();
        serve(1'b0, lat);
        cnt = 0;
        while (bif.IN_UART_TX_ACTIVE !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        chk("pre_reset_busy", 32'(bif.OUT_BUSY), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(bif.OUT_BUSY), 32'd0);
        chk("async_rst_launch", 32'(bif.OUT_UART_TX_LAUNCH), 32'd0);
        chk("async_rst_grant", 32'(bif.OUT_GRANT_ID), 32'd0);
        chk("async_rst_data", 32'(bif.OUT_UART_TX_DATA), 32'd0);
        cnt = 0;
        while ((bif.IN_UART_TX_ACTIVE !== 1'b0 || bif.IN_UART_TX_DONE !== 1'b0) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_lock = 1'b0;

        // All requesters valid: strict rotation from requester 0
        for (int k = 0; k < N; k++) rdata[k] = W'($urandom);
        vld = '1;
        drive();
        for (int f = 0; f < 8; f++) begin
            chk("rotation_order", 32'(model_pick(vld)), 32'(f % N));
            serve(1'b1, lat);
            wait_idle();
        end
        vld = '0;
        drive();
        repeat (2) @(negedge clk);

`ifdef UART_ARB_PACKET_LOCK_EN
        // Requester 1 owns a three-pack packet while 0 and 3 wait
        vld[0] = 1'b1;
        drive();
        serve(1'b0, lat);
        wait_idle();
        vld       = 4'b1011;
        m_last    = 4'b1101;
        for (int k = 0; k < N; k++) rdata[k] = W'($urandom);
        drive();
        for (int p = 0; p < 3; p++) begin
            if (p == 2) begin
                m_last[1] = 1'b1;
                drive();
            end
            chk("lock_owner", 32'(model_pick(vld)), 32'd1);
            serve(1'b1, lat);
            wait_idle();
        end
        vld[1] = 1'b0;
        drive();
        chk("release_next", 32'(model_pick(vld)), 32'd3);
        serve(1'b0, lat);
        wait_idle();
        chk("release_wrap", 32'(model_pick(vld)), 32'd0);
        serve(1'b0, lat);
        wait_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
